// File: rtl/video_pkg.sv
// video_pkg: shared defaults, width helper and read FSM encoding for the video pixel path
package video_pkg;
  localparam int CHAR_W_DEF = 10;
  localparam int CHARS_DEF = 64;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic {IDLE, ACTIVE} rd_state_e;
endpackage

// File: rtl/line_bank.sv
// line_bank: one line of glyph slices with slice write, synchronous clear and bit read
module line_bank
  import video_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int CHARS = CHARS_DEF,
  parameter int CIW = clog2w(CHARS),
  parameter int BW = clog2w(CHAR_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [CIW-1:0]    wr_idx,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic [CIW-1:0]    rd_char,
  input  logic [BW-1:0]     rd_bit,
  output logic              rd_pix
);
  logic [CHAR_W-1:0] mem_q [CHARS];
  logic [CHAR_W-1:0] mem_d [CHARS];
  // only indices below CHARS can match, so out-of-range writes fall through
  always_comb begin
    for (int i = 0; i < CHARS; i++)
      mem_d[i] = clr ? '0 : (wr_en && 32'(wr_idx) == i) ? wr_data : mem_q[i];
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_pix = mem_q[rd_char][rd_bit];
endmodule

// File: rtl/pingpong_line_buffer.sv
// pingpong_line_buffer: double-buffered character line, filled by slice and streamed one pixel per PIX_EN
module pingpong_line_buffer
  import video_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int CHARS = CHARS_DEF,
  parameter bit MSB_FIRST = 1,
  parameter bit CLEAR_ON_SWAP = 1,
  localparam int CIW = clog2w(CHARS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [CIW-1:0]    WR_CHAR,
  input  logic [CHAR_W-1:0] WR_DATA,
  input  logic              WR_DONE,
  output logic              BUF_READY,
  input  logic              RD_START,
  input  logic              PIX_EN,
  output logic              PIX_OUT,
  output logic              PIX_VALID,
  output logic              UNDERRUN
);
  localparam int BW = clog2w(CHAR_W);
  localparam int PW = clog2w(CHARS * CHAR_W);
  rd_state_e state_q, state_d;
  logic rd_bank_q, rd_bank_d, full_q, full_d, underrun_q, underrun_d;
  logic pix_out_q, pix_out_d, pix_valid_q, pix_valid_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CIW-1:0] char_q, char_d;
  logic [BW-1:0] bit_q, bit_d, bit_sel;
  logic done_ok, swap, emit;
  logic [1:0] bank_pix;
  // WR_DONE is folded in before the swap decision so a same-cycle done still swaps
  assign done_ok = WR_DONE && !full_q;
  assign swap = RD_START && (full_q || done_ok);
  assign emit = state_q == ACTIVE && PIX_EN;
  assign bit_sel = MSB_FIRST ? BW'(CHAR_W - 1) - bit_q : bit_q;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_bank #(.CHAR_W(CHAR_W), .CHARS(CHARS), .CIW(CIW), .BW(BW)) u_bank (
      .clk(CLK),
      .clr(!RESET || (CLEAR_ON_SWAP && swap && rd_bank_q == 1'(b))),
      .wr_en(WR_EN && !full_q && rd_bank_q != 1'(b)),
      .wr_idx(WR_CHAR),
      .wr_data(WR_DATA),
      .rd_char(char_q),
      .rd_bit(bit_sel),
      .rd_pix(bank_pix[b])
    );
  end
  always_comb begin
    rd_bank_d = rd_bank_q ^ swap;
    full_d = (full_q || done_ok) && !swap;
    underrun_d = underrun_q || (RD_START && !swap);
    state_d = state_q;
    cnt_d = cnt_q;
    char_d = char_q;
    bit_d = bit_q;
    pix_valid_d = emit;
    pix_out_d = emit ? bank_pix[rd_bank_q] : PIX_EN ? 1'b0 : pix_out_q;
    if (emit) begin
      cnt_d = cnt_q + 1'b1;
      bit_d = (bit_q == BW'(CHAR_W - 1)) ? '0 : bit_q + 1'b1;
      char_d = (bit_q == BW'(CHAR_W - 1)) ? char_q + 1'b1 : char_q;
      state_d = (cnt_q == PW'(CHARS * CHAR_W - 1)) ? IDLE : ACTIVE;
    end
    if (RD_START) begin
      state_d = ACTIVE;
      cnt_d = '0;
      char_d = '0;
      bit_d = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      rd_bank_q <= 1'b0;
      full_q <= 1'b0;
      underrun_q <= 1'b0;
      pix_out_q <= 1'b0;
      pix_valid_q <= 1'b0;
      cnt_q <= '0;
      char_q <= '0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      rd_bank_q <= rd_bank_d;
      full_q <= full_d;
      underrun_q <= underrun_d;
      pix_out_q <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      cnt_q <= cnt_d;
      char_q <= char_d;
      bit_q <= bit_d;
    end
  end
  assign BUF_READY = !full_q;
  assign PIX_OUT = pix_out_q;
  assign PIX_VALID = pix_valid_q;
  assign UNDERRUN = underrun_q;
endmodule

// File: doc/pingpong_line_buffer.md
# pingpong_line_buffer

Parametrised, double-buffered character line buffer for the video card pixel path. The character/font stage writes one glyph-row slice per character into a fill bank. The raster stage streams the other bank out serially, one pixel per pixel-enable. Banks swap at the start of each active line, so filling the next line never corrupts the one being displayed.

## Interface
Parameters:
- CHAR_W, 10, pixels per character slice
- CHARS, 64, characters per line; line length = CHARS*CHAR_W pixels
- MSB_FIRST, 1, 1: WR_DATA[CHAR_W-1] is the leftmost pixel of a character; 0: WR_DATA[0] is the leftmost pixel
- CLEAR_ON_SWAP, 1, 1: the new fill bank is zeroed on swap

Ports:
- CLK  in  1  system clock, all logic on posedge
- RESET  in  1  reset RESET, synchronous, active-low
- WR_EN  in  1  write strobe for fill bank
- WR_CHAR  in  CIW=$clog2(CHARS)  character index; 0 = leftmost
- WR_DATA  in  CHAR_W  glyph row slice
- WR_DONE  in  1  pulse: fill bank complete, eligible for display
- BUF_READY  out  1  fill bank accepts writes (not yet marked done)
- RD_START  in  1  pulse: start of active line
- PIX_EN  in  1  pixel clock enable
- PIX_OUT  out  1  current pixel
- PIX_VALID  out  1  PIX_OUT carries an active-line pixel this cycle
- UNDERRUN  out  1  sticky: a line start found no completed fill bank

## Operation
- Two banks of CHARS*CHAR_W bits; rd_bank selects the display bank, and the fill bank is !rd_bank. A full flag belongs to the fill bank.
- Write: WR_EN && BUF_READY stores WR_DATA at slice WR_CHAR of the fill bank. WR_CHAR >= CHARS is ignored. WR_EN while !BUF_READY is ignored.
- WR_DONE && BUF_READY sets full, which drives BUF_READY low. WR_DONE while full is ignored.
- RD_START with full:
  - toggle rd_bank and clear full;
  - zero the new fill bank if CLEAR_ON_SWAP.
- RD_START without full: keep rd_bank, so the previous line repeats, and set UNDERRUN. UNDERRUN clears only on reset.
- Read FSM:
  - IDLE -> ACTIVE on RD_START, with the pixel counter cleared.
  - ACTIVE: each PIX_EN emits the bank bit for (char = cnt / CHAR_W, bit = cnt % CHAR_W, ordered per MSB_FIRST), then increments cnt.
  - ACTIVE -> IDLE on the PIX_EN that emits pixel CHARS*CHAR_W-1.
- RD_START while ACTIVE aborts the line and restarts at pixel 0, with the same swap/underrun rules.
- Simultaneous WR_DONE and RD_START: WR_DONE is honoured first, so the swap happens.
- Simultaneous WR_EN and RD_START with a swap: the write lands in the old fill bank, which becomes the display bank.
- PIX_EN in IDLE: PIX_OUT=0, PIX_VALID=0 (blanking).
- Reset:
  - both banks zeroed, rd_bank=0, full=0, FSM IDLE, cnt=0;
  - outputs PIX_OUT=0, PIX_VALID=0, UNDERRUN=0, BUF_READY=1.
  - Reset mid-line abandons the line immediately.

## Timing
- Write at edge t is stored at t+1. BUF_READY falls at t+1 after an accepted WR_DONE at t.
- RD_START at t: swap and ACTIVE take effect at t+1, and BUF_READY rises at t+1 if a swap occurred. PIX_EN at t itself is treated per the pre-RD_START state.
- PIX_EN in ACTIVE at t: PIX_OUT and PIX_VALID are registered at t+1. PIX_VALID is high for exactly that one cycle; PIX_OUT holds its value until the next PIX_EN.
- Fixed latency: 1 cycle from PIX_EN to pixel. Throughput: 1 pixel per cycle with PIX_EN held high.
- The counter is $clog2(CHARS*CHAR_W) bits wide. Char/bit are derived by a char counter plus a bit counter that wraps at CHAR_W-1; there is no divider.

## Structure
- Shared package video_pkg holds:
  - default CHAR_W and CHARS;
  - a clog2-based width function for CIW and the pixel count;
  - the read FSM state encoding (IDLE, ACTIVE).
- Sub-module line_bank, instantiated twice, containing:
  - CHARS*CHAR_W register array;
  - slice write port (en, idx, data);
  - synchronous clear;
  - a combinational bit read at (char, bit).
- The top level owns rd_bank, full, UNDERRUN, the FSM and the counters.

## Test plan
- Use CHARS=4, CHAR_W=10, MSB_FIRST=1 unless noted.
- Reset: after RESET low for 2 cycles -> BUF_READY=1, PIX_VALID=0, PIX_OUT=0, UNDERRUN=0.
- Basic line:
  - write chars 0..3 = 10'h3FF, 10'h000, 10'h201, 10'h155; WR_DONE; RD_START; PIX_EN held high;
  - -> 40 PIX_VALID pulses carrying ten 1s, ten 0s, 1000000001, 0101010101, then IDLE; BUF_READY=1 after the swap.
- Underrun: RD_START with no WR_DONE -> UNDERRUN=1 and the previous line repeats bit-exact; with CLEAR_ON_SWAP=1 and nothing ever written, all pixels are 0.
- Ping-pong isolation: during line streaming, write the fill bank with all 10'h2AA and pulse WR_DONE. Required response:
  - the current line output is unchanged;
  - the next RD_START streams the 1010101010 pattern;
  - writes after WR_DONE are ignored.
- Simultaneous WR_DONE+RD_START in one cycle -> swap occurs and UNDERRUN stays 0. RD_START mid-line at pixel 17 -> restart at pixel 0 of the new bank.
- MSB_FIRST=0 and gapped PIX_EN (every 3rd cycle): WR_DATA=10'h001 at char 0 -> first pixel 1, next nine 0. PIX_VALID appears exactly 1 cycle after each PIX_EN. Reset asserted at pixel 5 -> PIX_VALID=0 next cycle, and the FSM is IDLE.
